// File: rtl/rpn_pkg.sv
// Shared types for the RPN sequencer: opcodes, FSM states, calculator op codes
// and the program instruction word layout.
package rpn_pkg;

    localparam int unsigned RPN_AW = 10;
    localparam int unsigned RPN_DW = 16;

    typedef enum logic [2:0] {
        OPC_NOP  = 3'b000,
        OPC_PUSH = 3'b001,
        OPC_NEG  = 3'b010,
        OPC_ADD  = 3'b011,
        OPC_MUL  = 3'b100,
        OPC_JZ   = 3'b101,
        OPC_JMP  = 3'b110,
        OPC_HALT = 3'b111
    } rpn_opc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } rpn_state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_NEG  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef struct packed {
        rpn_opc_t          opc;
        logic [RPN_DW-1:0] imm;
    } rpn_instr_t;

endpackage

// File: rtl/rpn_prog_mem.sv
// Program memory: 2^AW words, synchronous write, asynchronous read, no reset.
module rpn_prog_mem #(
    parameter int unsigned AW = 10,
    parameter int unsigned WW = 19
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem_q [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// Program-driven command issuer for the RPN calculator; one instruction per step.
// Optional stack-bound checking is enabled with `define RPN_SEQ_STACKCHK_EN.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16
) (
    input  logic          step,
    input  logic          nrst,
    input  logic          start,
    input  logic          stop,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW+2:0] prog_data,
    input  logic [DW-1:0] stack_top,
    input  logic [AW-1:0] stack_cnt,
    output logic          push,
    output logic [1:0]    op,
    output logic [DW-1:0] d,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    rpn_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW+2:0] instr;
    rpn_opc_t      opc;
    logic [DW-1:0] imm;
    logic          fault;
    logic          jz_take;

    rpn_prog_mem #(
        .AW (AW),
        .WW (DW + 3)
    ) u_mem (
        .clk   (step),
        .we    (prog_we && (state_q != ST_RUN)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign opc     = rpn_opc_t'(instr[DW+2:DW]);
    assign imm     = instr[DW-1:0];
    assign jz_take = (stack_cnt != '0) && (stack_top == '0);

`ifdef RPN_SEQ_STACKCHK_EN
    always_comb begin
        fault = 1'b0;
        case (opc)
            OPC_PUSH:         fault = (stack_cnt == '1);
            OPC_NEG:          fault = (stack_cnt == '0);
            OPC_ADD, OPC_MUL: fault = (stack_cnt < AW'(2));
            default:          fault = 1'b0;
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // stop outranks HALT and faults; both leave pc on the current instruction
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (fault) begin
                    state_d = ST_ERR;
                end else begin
                    case (opc)
                        OPC_JZ:   pc_d = jz_take ? imm[AW-1:0] : pc_q + AW'(1);
                        OPC_JMP:  pc_d = imm[AW-1:0];
                        OPC_HALT: state_d = ST_DONE;
                        default:  pc_d = pc_q + AW'(1);
                    endcase
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
        endcase
    end

    always_comb begin
        push = 1'b0;
        op   = OP_NONE;
        d    = '0;
        if ((state_q == ST_RUN) && !stop && !fault) begin
            case (opc)
                OPC_PUSH: begin
                    push = 1'b1;
                    d    = imm;
                end
                OPC_NEG: op = OP_NEG;
                OPC_ADD: op = OP_ADD;
                OPC_MUL: op = OP_MUL;
                default: op = OP_NONE;
            endcase
        end
    end

    assign pc   = pc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
`ifdef RPN_SEQ_STACKCHK_EN
    assign err  = (state_q == ST_ERR);
`else
    assign err  = 1'b0;
`endif

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Program-driven instruction issuer sitting directly upstream of the RPN stack calculator. Holds a 1024-word program memory, and while running fetches one instruction per clock. Each fetched instruction is translated into the calculator's `push`/`op`/`d` command inputs for that same edge. Reads the calculator's top-of-stack and element count back for conditional jumps and stack-bound checking.

## Interface
- `AW`, 10: program/stack address width; must match the calculator counter width.
- `DW`, 16: data width of immediates and `stack_top`.
- `step  in  1`: clock; all state updates on posedge.
- `nrst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: begin execution at address 0.
- `stop  in  1`: abort execution.
- `prog_we  in  1`: program memory write enable.
- `prog_addr  in  AW`: program write address.
- `prog_data  in  3+DW`: instruction word, `{opc[2:0], imm[DW-1:0]}`.
- `stack_top  in  DW`: calculator top-of-stack register.
- `stack_cnt  in  AW`: calculator element count.
- `push  out  1`: command to calculator.
- `op  out  2`: command to calculator; 01 NEG, 10 ADD, 11 MUL, 00 none.
- `d  out  DW`: push data.
- `pc  out  AW`: address of the current instruction.
- `busy  out  1`: state is RUN.
- `done  out  1`: state is DONE.
- `err  out  1`: state is ERR.

## Operation
- FSM states: IDLE, RUN, DONE, ERR. Reset puts the FSM in IDLE with pc=0, and all outputs read 0.
- IDLE/DONE/ERR plus `start`: on the next edge, go to RUN with pc=0.
- In RUN, `start` is ignored.
- In RUN, `stop` has top priority:
  - commands are forced to 0 that cycle;
  - the next state is IDLE;
  - pc holds.
- Opcodes, decoded combinationally from `mem[pc]` while in RUN:
  - 000 NOP: no command; pc+1.
  - 001 PUSH: `push`=1, `d`=imm; pc+1.
  - 010 NEG: `op`=01; pc+1.
  - 011 ADD: `op`=10; pc+1.
  - 100 MUL: `op`=11; pc+1.
  - 101 JZ: no command; pc = imm[AW-1:0] if `stack_cnt`≠0 and `stack_top`==0, else pc+1.
  - 110 JMP: no command; pc = imm[AW-1:0].
  - 111 HALT: no command; the next state is DONE and pc holds.
- Outside RUN, `push`=0, `op`=00, and `d`=0.
- pc wraps 1023→0 on sequential advance.
- Program writes:
  - accepted only when not in RUN; `prog_we` is ignored in RUN;
  - memory write is synchronous, read is asynchronous;
  - memory is not reset.

## Timing
- Issue latency is zero. Commands for `mem[pc]` are valid during the cycle, and the calculator consumes them on the same posedge that advances pc.
- `stack_top` and `stack_cnt` seen by JZ reflect all previously issued instructions.
- First instruction issue happens in the cycle after `start` is sampled.
- `done`/`err` go high on the edge after HALT or the fault. They stay high until the next `start` edge.
- Async `nrst` mid-RUN: the FSM goes to IDLE and pc to 0 immediately, and commands drop to 0 without waiting for a clock.

## Configuration
- `RPN_SEQ_STACKCHK_EN` defined: the instruction is checked before issue against bounds. A fault forces commands to 0 that cycle, the next state is ERR, and pc holds at the faulting instruction. Fault conditions:
  - PUSH with `stack_cnt`==2^AW−1;
  - NEG with `stack_cnt`==0;
  - ADD or MUL with `stack_cnt`<2.
- Undefined: no checks are made, `err` is tied 0, and ERR is unreachable. Faulting instructions are issued, and the calculator drops them silently.

## Structure
- Shared package `rpn_pkg` contains:
  - opcode enum `rpn_opc_t`;
  - state enum;
  - the calculator op codes (`OP_NEG`=01, `OP_ADD`=10, `OP_MUL`=11);
  - the instruction struct `{opc, imm}`.
- One sub-module, `rpn_prog_mem`: 1024×(3+DW), synchronous write, asynchronous read.

## Test plan
- Load program PUSH 3, PUSH 4, ADD, HALT and start, with the real calculator attached.
  - Response: `stack_top`=7 and `stack_cnt`=1.
  - `done` rises 4 edges after the first issue, with pc=3.
- Load PUSH 5, NEG, PUSH −2, MUL, HALT.
  - Response: `stack_top`=10.
- Load PUSH 0, JZ 4, PUSH 9, HALT, PUSH 1, HALT.
  - Response: pc sequence 0,1,4,5, and `stack_top`=1 with `stack_cnt`=2.
- With `RPN_SEQ_STACKCHK_EN` defined, load ADD at address 0 with an empty stack.
  - Response: `err` rises after 1 edge, pc=0, and `op` is never nonzero.
- Load JMP 0 loop, then assert `stop` on cycle 5.
  - Response: IDLE next edge and `busy`=0.
  - A `prog_we` pulse during RUN leaves memory unchanged.
- Pulse `nrst` low mid-run with no clock edge.
  - Response: `busy`, `push`, `op`, and pc are 0 immediately.
  - A following `start` restarts at address 0.
